// File: rtl/bitmask_enumerator_constant_popcount.sv
// Walks every WORD_WIDTH-bit mask sharing the seed's popcount in ascending
// order with wraparound, one mask per handshake on a valid/ready stream.
module bitmask_enumerator_constant_popcount #(
    parameter int WORD_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   clear_n,
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic [WORD_WIDTH-1:0]  start_word,
    input  logic                   abort,
    output logic                   mask_valid,
    input  logic                   mask_ready,
    output logic [WORD_WIDTH-1:0]  mask_out,
    output logic                   mask_last,
    output logic [COUNT_WIDTH-1:0] mask_index
);

    localparam int POP_WIDTH = $clog2(WORD_WIDTH + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                  state_reg, state_next;
    logic [WORD_WIDTH-1:0]   seed_reg, seed_next;
    logic [WORD_WIDTH-1:0]   current_reg, current_next;
    logic [COUNT_WIDTH-1:0]  index_reg, index_next;

    logic [WORD_WIDTH-1:0]   low_bit;
    logic [WORD_WIDTH-1:0]   ripple;
    logic [WORD_WIDTH-1:0]   changed;
    logic [WORD_WIDTH-1:0]   fill_wrap;
    logic [WORD_WIDTH-1:0]   fill_step;
    logic [WORD_WIDTH-1:0]   succ;
    logic                    carry;
    logic [POP_WIDTH-1:0]    pop_current;
    logic [POP_WIDTH-1:0]    pop_changed;
    logic [POP_WIDTH-1:0]    step_count;

    // Adding the lowest set bit moves the lowest run of ones up by one place;
    // the ones it swallowed beyond the moved bit are re-packed at the bottom.
    assign low_bit          = current_reg & (~current_reg + WORD_WIDTH'(1));
    assign {carry, ripple}  = {1'b0, current_reg} + {1'b0, low_bit};
    assign changed          = current_reg ^ ripple;

    always_comb begin
        pop_current = '0;
        pop_changed = '0;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            pop_current = pop_current + POP_WIDTH'(current_reg[i]);
            pop_changed = pop_changed + POP_WIDTH'(changed[i]);
        end
    end

    assign step_count = (pop_changed >= POP_WIDTH'(2)) ? (pop_changed - POP_WIDTH'(2)) : '0;

    generate
        for (genvar gi = 0; gi < WORD_WIDTH; gi++) begin : g_fill
            assign fill_wrap[gi] = (POP_WIDTH'(gi) < pop_current);
            assign fill_step[gi] = (POP_WIDTH'(gi) < step_count);
        end
    endgenerate

    // A carry out means current was the largest mask of its popcount:
    // wrap to the smallest one, all ones packed at the bottom.
    assign succ = carry ? fill_wrap : (ripple | fill_step);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_reg   <= IDLE;
            seed_reg    <= '0;
            current_reg <= '0;
            index_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            seed_reg    <= seed_next;
            current_reg <= current_next;
            index_reg   <= index_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        seed_next    = seed_reg;
        current_next = current_reg;
        index_next   = index_reg;
        case (state_reg)
            IDLE: begin
                if (start_valid) begin
                    state_next   = RUN;
                    seed_next    = start_word;
                    current_next = start_word;
                    index_next   = '0;
                end
            end
            RUN: begin
                // abort wins over a simultaneous handshake: the mask is dropped
                if (abort) begin
                    state_next = IDLE;
                end else if (mask_ready) begin
                    if (mask_last) begin
                        state_next = IDLE;
                    end else begin
                        current_next = succ;
                        index_next   = index_reg + COUNT_WIDTH'(1);
                    end
                end
            end
        endcase
    end

    assign start_ready = (state_reg == IDLE);
    assign mask_valid  = (state_reg == RUN);
    assign mask_out    = current_reg;
    assign mask_index  = index_reg;
    assign mask_last   = (succ == seed_reg) || (seed_reg == '0);

endmodule

// File: tb/tb_bitmask_enumerator_constant_popcount.sv
// Bench for the constant-popcount enumerator at WORD_WIDTH=4: fixed vectors,
// random seeds with backpressure against an enumerate-and-rotate model, abort and reset.
module tb_bitmask_enumerator_constant_popcount;

    logic        clock;
    logic        clear_n;
    logic        start_valid;
    logic        start_ready;
    logic [3:0]  start_word;
    logic        abort;
    logic        mask_valid;
    logic        mask_ready;
    logic [3:0]  mask_out;
    logic        mask_last;
    logic [15:0] mask_index;

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_q[$];

    typedef struct packed {
        logic [3:0]       seed;
        logic [3:0]       len;
        logic [5:0][3:0]  stream;
    } vec_t;

    vec_t vecs[4];

    bitmask_enumerator_constant_popcount #(
        .WORD_WIDTH  (4),
        .COUNT_WIDTH (16)
    ) dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .start_word  (start_word),
        .abort       (abort),
        .mask_valid  (mask_valid),
        .mask_ready  (mask_ready),
        .mask_out    (mask_out),
        .mask_last   (mask_last),
        .mask_index  (mask_index)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // All masks with the seed's popcount in ascending order, rotated to start at the seed.
    function automatic void build_model(input logic [3:0] seed);
        logic [3:0] all_q[$];
        int p;
        exp_q.delete();
        p = 0;
        for (int v = 0; v < 16; v++)
            if ($countones(4'(v)) == $countones(seed)) all_q.push_back(4'(v));
        for (int i = 0; i < all_q.size(); i++)
            if (all_q[i] == seed) p = i;
        for (int i = 0; i < all_q.size(); i++)
            exp_q.push_back(all_q[(p + i) % all_q.size()]);
    endfunction

    task automatic start_seed(input logic [3:0] seed);
        check("start_ready_before", 32'(start_ready), 32'd1);
        start_valid = 1'b1;
        start_word  = seed;
        @(negedge clock);
        start_valid = 1'b0;
        check("valid_after_start", 32'(mask_valid), 32'd1);
    endtask

    // Consume exp_q; random_ready applies random backpressure and checks stability.
    task automatic drain(input bit random_ready);
        int idx = 0;
        int cycles = 0;
        bit prev_stall = 1'b0;
        logic [3:0]  prev_out = '0;
        logic [15:0] prev_idx = '0;
        logic        prev_last = 1'b0;
        logic        rdy;
        while (idx < exp_q.size() && cycles < 64) begin
            check("stream_valid", 32'(mask_valid), 32'd1);
            check("stream_out", 32'(mask_out), 32'(exp_q[idx]));
            check("stream_index", 32'(mask_index), 32'(idx));
            check("stream_last", 32'(mask_last), 32'(idx == exp_q.size() - 1));
            if (prev_stall) begin
                check("stall_out", 32'(mask_out), 32'(prev_out));
                check("stall_index", 32'(mask_index), 32'(prev_idx));
                check("stall_last", 32'(mask_last), 32'(prev_last));
            end
            rdy = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            mask_ready = rdy;
            prev_stall = !rdy;
            prev_out   = mask_out;
            prev_idx   = mask_index;
            prev_last  = mask_last;
            if (rdy) begin
                $display("mask idx=%0d out=%b last=%b", mask_index, mask_out, mask_last);
                idx++;
            end
            @(negedge clock);
            cycles++;
        end
        mask_ready = 1'b0;
        if (cycles >= 64) check("drain_timeout", 32'(cycles), 32'd0);
        check("done_valid", 32'(mask_valid), 32'd0);
        check("done_start_ready", 32'(start_ready), 32'd1);
    endtask

    initial begin
        vecs[0] = '{seed: 4'b0011, len: 4'd6,
                    stream: {4'b1100, 4'b1010, 4'b1001, 4'b0110, 4'b0101, 4'b0011}};
        vecs[1] = '{seed: 4'b0110, len: 4'd6,
                    stream: {4'b0101, 4'b0011, 4'b1100, 4'b1010, 4'b1001, 4'b0110}};
        vecs[2] = '{seed: 4'b0000, len: 4'd1, stream: '0};
        vecs[3] = '{seed: 4'b1111, len: 4'd1, stream: {20'd0, 4'b1111}};

        clear_n     = 1'b0;
        start_valid = 1'b0;
        start_word  = '0;
        abort       = 1'b0;
        mask_ready  = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_valid", 32'(mask_valid), 32'd0);
        clear_n = 1'b1;
        @(negedge clock);
        check("rst_start_ready", 32'(start_ready), 32'd1);
        check("rst_out", 32'(mask_out), 32'd0);
        check("rst_index", 32'(mask_index), 32'd0);
        check("rst_last", 32'(mask_last), 32'd1);

        // Fixed vectors
        for (int v = 0; v < 4; v++) begin
            exp_q.delete();
            for (int i = 0; i < int'(vecs[v].len); i++) exp_q.push_back(vecs[v].stream[i]);
            start_seed(vecs[v].seed);
            drain(1'b0);
        end

        // Backpressure on seed 0011
        build_model(4'b0011);
        start_seed(4'b0011);
        drain(1'b1);

        // Random seeds with backpressure
        for (int n = 0; n < 16; n++) begin
            logic [3:0] s;
            s = 4'($urandom_range(0, 15));
            build_model(s);
            start_seed(s);
            drain(1'b1);
        end

        // Abort on mask_index 2 with a start offered throughout RUN
        build_model(4'b0011);
        start_seed(4'b0011);
        start_valid = 1'b1;
        start_word  = 4'b1111;
        mask_ready  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check("abort_pre_out", 32'(mask_out), 32'(exp_q[i]));
            @(negedge clock);
        end
        check("abort_present", 32'(mask_out), 32'b0110);
        abort      = 1'b1;
        start_word = 4'b0101;
        @(negedge clock);
        abort      = 1'b0;
        mask_ready = 1'b0;
        check("abort_valid", 32'(mask_valid), 32'd0);
        check("abort_start_ready", 32'(start_ready), 32'd1);
        check("abort_out_held", 32'(mask_out), 32'b0110);
        check("abort_index_held", 32'(mask_index), 32'd2);
        @(negedge clock);
        start_valid = 1'b0;
        check("restart_out", 32'(mask_out), 32'b0101);
        check("restart_index", 32'(mask_index), 32'd0);
        build_model(4'b0101);
        drain(1'b0);

        // abort together with start in IDLE: start wins
        abort = 1'b1;
        start_seed(4'b0011);
        abort = 1'b0;
        build_model(4'b0011);
        drain(1'b0);

        // Reset while presenting 1001
        build_model(4'b0011);
        start_seed(4'b0011);
        mask_ready = 1'b1;
        repeat (3) @(negedge clock);
        mask_ready = 1'b0;
        check("reset_present", 32'(mask_out), 32'b1001);
        #2 clear_n = 1'b0;
        #1;
        check("reset_async_valid", 32'(mask_valid), 32'd0);
        check("reset_async_ready", 32'(start_ready), 32'd1);
        @(negedge clock);
        clear_n = 1'b1;
        @(negedge clock);
        check("post_reset_ready", 32'(start_ready), 32'd1);
        check("post_reset_out", 32'(mask_out), 32'd0);
        check("post_reset_index", 32'(mask_index), 32'd0);
        start_seed(4'b0011);
        drain(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
